instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/vsmp_pkg.sv | 53 +++++
 rtl/instr_decode.sv | 51 +++++
 rtl/instr_sequencer.sv | 123 ++++++++++++
 tb/tb_instr_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsmp_pkg.sv
// Shared encodings for the four-word instruction sequencer: FSM states, opcodes,
// PHASE one-hot codes and the datapath strobe bundle.
package vsmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] PH_NONE      = 4'b0000;
  localparam logic [3:0] PH_FETCH     = 4'b0001;
  localparam logic [3:0] PH_DECODE    = 4'b0010;
  localparam logic [3:0] PH_EXECUTE   = 4'b0100;
  localparam logic [3:0] PH_WRITEBACK = 4'b1000;

  // Field order matches the {LOADA, LOADB, ENABLEALU, ENABLEINSTR, ADDSUB} port group.
  typedef struct packed {
    logic load_a;
    logic load_b;
    logic enable_alu;
    logic enable_instr;
    logic add_sub;
  } strobes_t;

  localparam strobes_t STROBES_OFF = '0;

  function automatic logic [3:0] phase_of(input state_t s);
    case (s)
      ST_FETCH:     return PH_FETCH;
      ST_DECODE:    return PH_DECODE;
      ST_EXECUTE:   return PH_EXECUTE;
      ST_WRITEBACK: return PH_WRITEBACK;
      default:      return PH_NONE;
    endcase
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_LDA) || (op == OP_LDB) ||
           (op == OP_ADD) || (op == OP_SUB) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode-to-strobe decoder; strobes depend only on the registered
// state and latched opcode, so they are glitch-free Moore outputs.
module instr_decode
  import vsmp_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] instr,
  output strobes_t   strobes,
  output logic       illegal
);

  logic is_alu_op;

  assign is_alu_op = (instr == OP_ADD) || (instr == OP_SUB);
  assign illegal   = !is_legal(instr);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case
    // statements can leave a value unassigned and infer a latch.
    strobes = STROBES_OFF;
    case (state)
      ST_EXECUTE: begin
        case (instr)
          OP_LDA: begin
            strobes.enable_instr = 1'b1;
            strobes.load_a       = 1'b1;
          end
          OP_LDB: begin
            strobes.enable_instr = 1'b1;
            strobes.load_b       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            strobes.enable_alu = 1'b1;
            strobes.add_sub    = (instr == OP_SUB);
          end
          default: ;
        endcase
      end
      ST_WRITEBACK: begin
        // The ALU result is written back into A; ADDSUB stays stable across both phases.
        if (is_alu_op) begin
          strobes.enable_alu = 1'b1;
          strobes.load_a     = 1'b1;
          strobes.add_sub    = (instr == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Four-phase instruction sequencer for a 4-word program store: fetches, decodes,
// executes and writes back each word, with stall (HOLD), halt and error handling.
module instr_sequencer
  import vsmp_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       START,
  input  logic       HOLD,
  input  logic [7:0] MEM_WORD,
  output logic [1:0] PC,
  output logic [3:0] INSTR,
  output logic [3:0] DATA,
  output logic [3:0] PHASE,
  output logic       LOADA,
  output logic       LOADB,
  output logic       ENABLEALU,
  output logic       ENABLEINSTR,
  output logic       ADDSUB,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  state_t     state_q, state_d;
  logic [1:0] pc_q, pc_d;
  logic [3:0] instr_q, instr_d;
  logic [3:0] data_q, data_d;
  logic       err_q, err_d;
  logic       done_q, done_d;

  strobes_t   strobes;
  logic       illegal;

  instr_decode u_decode (
    .state   (state_q),
    .instr   (instr_q),
    .strobes (strobes),
    .illegal (illegal)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    data_d  = data_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (HOLD) begin
      // A pending end-of-run pulse is deferred until the stall is released.
      done_d = done_q;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (START) begin
            state_d = ST_FETCH;
            pc_d    = '0;
            err_d   = 1'b0;
          end
        end
        ST_FETCH: begin
          instr_d = MEM_WORD[7:4];
          data_d  = MEM_WORD[3:0];
          state_d = ST_DECODE;
        end
        ST_DECODE: begin
          if (instr_q == OP_HALT) begin
            state_d = ST_HALTED;
            done_d  = 1'b1;
          end else begin
            state_d = ST_EXECUTE;
            err_d   = err_q | illegal;
          end
        end
        ST_EXECUTE: state_d = ST_WRITEBACK;
        ST_WRITEBACK: begin
          pc_d = pc_q + 2'd1;
          if (pc_q == 2'd3) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    PHASE = phase_of(state_q);
    BUSY  = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    {LOADA, LOADB, ENABLEALU, ENABLEINSTR, ADDSUB} = HOLD ? STROBES_OFF : strobes;
    DONE  = done_q & ~HOLD;
    // ERR is already visible while the offending word sits in DECODE.
    ERR   = err_q | ((state_q == ST_DECODE) & illegal);
  end

  assign PC    = pc_q;
  assign INSTR = instr_q;
  assign DATA  = data_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs push expected strobe/DONE
// events into a queue, and a negedge monitor pops and compares each one the DUT shows.
module tb_instr_sequencer;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       START;
  logic       HOLD;
  logic [7:0] MEM_WORD;
  logic [1:0] PC;
  logic [3:0] INSTR, DATA, PHASE;
  logic       LOADA, LOADB, ENABLEALU, ENABLEINSTR, ADDSUB, BUSY, DONE, ERR;

  logic [7:0] prog [4];

  typedef struct packed {
    logic [3:0] phase;
    logic [4:0] strb;
    logic [3:0] data;
    logic [1:0] pc;
    logic       done;
    logic       err;
  } ev_t;

  localparam logic [4:0] S_NONE  = 5'b00000;
  localparam logic [4:0] S_LDA   = 5'b10010;
  localparam logic [4:0] S_LDB   = 5'b01010;
  localparam logic [4:0] S_ADD_E = 5'b00100;
  localparam logic [4:0] S_ADD_W = 5'b10100;
  localparam logic [4:0] S_SUB_E = 5'b00101;
  localparam logic [4:0] S_SUB_W = 5'b10101;
  localparam logic [3:0] P_NONE  = 4'b0000;
  localparam logic [3:0] P_FETCH = 4'b0001;
  localparam logic [3:0] P_EXEC  = 4'b0100;
  localparam logic [3:0] P_WB    = 4'b1000;

  ev_t exp_q [$];
  ev_t act_ev, exp_ev;
  int  n_compared   = 0;
  int  n_mismatched = 0;

  instr_sequencer dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .START       (START),
    .HOLD        (HOLD),
    .MEM_WORD    (MEM_WORD),
    .PC          (PC),
    .INSTR       (INSTR),
    .DATA        (DATA),
    .PHASE       (PHASE),
    .LOADA       (LOADA),
    .LOADB       (LOADB),
    .ENABLEALU   (ENABLEALU),
    .ENABLEINSTR (ENABLEINSTR),
    .ADDSUB      (ADDSUB),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERR         (ERR)
  );

  assign MEM_WORD = prog[PC];

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] ph, input logic [4:0] st, input logic [3:0] d,
                      input logic [1:0] pc, input logic dn, input logic er);
    exp_q.push_back({ph, st, d, pc, dn, er});
  endtask

  task automatic push_prog1();
    push(P_EXEC, S_LDA,   4'h3, 2'd0, 1'b0, 1'b0);
    push(P_EXEC, S_LDB,   4'h2, 2'd1, 1'b0, 1'b0);
    push(P_EXEC, S_ADD_E, 4'h0, 2'd2, 1'b0, 1'b0);
    push(P_WB,   S_ADD_W, 4'h0, 2'd2, 1'b0, 1'b0);
    push(P_NONE, S_NONE,  4'h0, 2'd0, 1'b1, 1'b0);
  endtask

  // Pulses START for one cycle, then counts cycles from the first FETCH to DONE.
  task automatic run_pulse(output int cycles, output logic [3:0] err_dec);
    cycles  = -1;
    err_dec = '0;
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    check("fetch_pc0", 32'({PHASE, PC}), 32'({P_FETCH, 2'd0}));
    for (int i = 0; i < 40; i++) begin
      if (PHASE == 4'b0010) err_dec[PC] = ERR;
      @(posedge CLK); #1;
      if (DONE) begin
        cycles = i + 1;
        break;
      end
    end
  endtask

  // Monitor: every cycle with an active strobe or DONE must match the next expected event.
  initial begin
    forever begin
      @(negedge CLK);
      if (RSTN === 1'b1 && (LOADA | LOADB | ENABLEALU | ENABLEINSTR | DONE)) begin
        act_ev = {PHASE, LOADA, LOADB, ENABLEALU, ENABLEINSTR, ADDSUB, DATA, PC, DONE, ERR};
        n_compared++;
        if (exp_q.size() == 0) begin
          n_mismatched++;
          $display("FAIL unexpected_event: got phase=%b strb=%b data=%h pc=%0d done=%b err=%b, none expected",
                   act_ev.phase, act_ev.strb, act_ev.data, act_ev.pc, act_ev.done, act_ev.err);
        end else begin
          exp_ev = exp_q.pop_front();
          if (act_ev !== exp_ev) begin
            n_mismatched++;
            $display("FAIL event: got phase=%b strb=%b data=%h pc=%0d done=%b err=%b, expected phase=%b strb=%b data=%h pc=%0d done=%b err=%b",
                     act_ev.phase, act_ev.strb, act_ev.data, act_ev.pc, act_ev.done, act_ev.err,
                     exp_ev.phase, exp_ev.strb, exp_ev.data, exp_ev.pc, exp_ev.done, exp_ev.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    int         c2;
    logic [3:0] ed;
    logic       found;

    RSTN  = 1'b0;
    START = 1'b0;
    HOLD  = 1'b0;
    prog  = '{8'h13, 8'h22, 8'h30, 8'h00};
    #12;
    check("reset_outputs", 32'({PC, INSTR, DATA, PHASE, LOADA, LOADB, ENABLEALU, ENABLEINSTR,
                                ADDSUB, BUSY, DONE, ERR}), 32'd0);
    #10 RSTN = 1'b1;

    // ADD program: LDA 3, LDB 2, ADD, NOP.
    push_prog1();
    run_pulse(cyc, ed);
    check("prog1_latency", 32'(cyc), 32'd16);
    check("prog1_idle", 32'({PHASE, PC, BUSY}), 32'({P_NONE, 2'd0, 1'b0}));
    @(posedge CLK); #1;
    check("prog1_done_one_cycle", 32'(DONE), 32'd0);

    // SUB program ending in HALT at word 3.
    prog = '{8'h17, 8'h25, 8'h40, 8'hF0};
    push(P_EXEC, S_LDA,   4'h7, 2'd0, 1'b0, 1'b0);
    push(P_EXEC, S_LDB,   4'h5, 2'd1, 1'b0, 1'b0);
    push(P_EXEC, S_SUB_E, 4'h0, 2'd2, 1'b0, 1'b0);
    push(P_WB,   S_SUB_W, 4'h0, 2'd2, 1'b0, 1'b0);
    push(P_NONE, S_NONE,  4'h0, 2'd3, 1'b1, 1'b0);
    run_pulse(cyc, ed);
    check("prog2_halt_latency", 32'(cyc), 32'd14);
    check("prog2_halted", 32'({PHASE, PC, BUSY}), 32'({P_NONE, 2'd3, 1'b0}));
    @(posedge CLK); #1;
    check("prog2_halted_hold", 32'({PHASE, PC, BUSY, DONE}), 32'({P_NONE, 2'd3, 1'b0, 1'b0}));

    // Illegal opcode 0x9 in word 1; started from HALTED.
    prog = '{8'h14, 8'h9A, 8'h26, 8'h30};
    push(P_EXEC, S_LDA,   4'h4, 2'd0, 1'b0, 1'b0);
    push(P_EXEC, S_LDB,   4'h6, 2'd2, 1'b0, 1'b1);
    push(P_EXEC, S_ADD_E, 4'h0, 2'd3, 1'b0, 1'b1);
    push(P_WB,   S_ADD_W, 4'h0, 2'd3, 1'b0, 1'b1);
    push(P_NONE, S_NONE,  4'h0, 2'd0, 1'b1, 1'b1);
    run_pulse(cyc, ed);
    check("prog3_latency", 32'(cyc), 32'd16);
    check("prog3_err_in_decode", 32'(ed), 32'(4'b1110));
    @(posedge CLK); #1;
    check("prog3_err_sticky", 32'(ERR), 32'd1);

    // HOLD for 5 cycles during EXECUTE of LDA; the new START also clears ERR.
    prog = '{8'h15, 8'h00, 8'h00, 8'h00};
    push(P_EXEC, S_LDA,  4'h5, 2'd0, 1'b0, 1'b0);
    push(P_NONE, S_NONE, 4'h0, 2'd0, 1'b1, 1'b0);
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    check("hold_err_cleared", 32'({PHASE, ERR}), 32'({P_FETCH, 1'b0}));
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("hold_reach_execute", 32'(PHASE), 32'(P_EXEC));
    HOLD = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      check("hold_frozen", 32'({PHASE, PC, INSTR, LOADA, ENABLEINSTR, BUSY}),
            32'({P_EXEC, 2'd0, 4'h1, 1'b0, 1'b0, 1'b1}));
    end
    HOLD = 1'b0;
    #1;
    check("hold_release_strobes", 32'({LOADA, ENABLEINSTR}), 32'(2'b11));
    @(posedge CLK); #1;
    check("hold_strobe_one_cycle", 32'({PHASE, LOADA, ENABLEINSTR}), 32'({P_WB, 1'b0, 1'b0}));
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        found = 1'b1;
        break;
      end
    end
    check("hold_run_done", 32'(found), 32'd1);

    // Asynchronous reset during WRITEBACK of ADD, then a clean rerun.
    prog = '{8'h13, 8'h22, 8'h30, 8'h00};
    push(P_EXEC, S_LDA,   4'h3, 2'd0, 1'b0, 1'b0);
    push(P_EXEC, S_LDB,   4'h2, 2'd1, 1'b0, 1'b0);
    push(P_EXEC, S_ADD_E, 4'h0, 2'd2, 1'b0, 1'b0);
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (PHASE == P_WB && ENABLEALU) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reach_wb_add", 32'(found), 32'd1);
    #1 RSTN = 1'b0;
    #1;
    check("rst_async_outputs", 32'({PC, INSTR, DATA, PHASE, LOADA, LOADB, ENABLEALU, ENABLEINSTR,
                                    ADDSUB, BUSY, DONE, ERR}), 32'd0);
    check("rst_queue_drained", 32'(exp_q.size()), 32'd0);
    @(posedge CLK); #1 RSTN = 1'b1;
    push_prog1();
    run_pulse(cyc, ed);
    check("rst_rerun_latency", 32'(cyc), 32'd16);

    // START held high: back-to-back runs, DONE every 17 cycles.
    push_prog1();
    push_prog1();
    @(posedge CLK); #1 START = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        found = 1'b1;
        break;
      end
    end
    check("b2b_first_done", 32'(found), 32'd1);
    c2 = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        c2 = i + 1;
        break;
      end
    end
    START = 1'b0;
    check("b2b_done_period", 32'(c2), 32'd17);
    @(posedge CLK); #1;
    check("b2b_stays_idle", 32'({PHASE, BUSY}), 32'({P_NONE, 1'b0}));

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
